// File: rtl/operand_issue_pkg.sv
// ============================================================================
// Module   : operand_issue_pkg
// Brief    : Shared sizing defaults and writeback-source encoding for operand_issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

package operand_issue_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    // Single-entry register files still need a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [0:0] {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

endpackage

`default_nettype wire

// File: rtl/operand_issue_if.sv
// ============================================================================
// Module   : operand_issue_if
// Brief    : Issue, operand, register-file and writeback signals of operand_issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface operand_issue_if import operand_issue_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) ();

    localparam int AW = addr_width(DEPTH);

    logic             iss_valid;
    logic             iss_ready;
    logic [AW-1:0]    iss_rs1;
    logic [AW-1:0]    iss_rs2;
    logic [AW-1:0]    iss_rd;
    logic             iss_rd_we;

    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [AW-1:0]    op_rd;
    logic             op_rd_we;

    logic [AW-1:0]    rf_rd_addr0;
    logic [AW-1:0]    rf_rd_addr1;
    logic [WIDTH-1:0] rf_dout0;
    logic [WIDTH-1:0] rf_dout1;
    logic [AW-1:0]    rf_wr_addr0;
    logic [WIDTH-1:0] rf_wr_din0;
    logic             rf_we0;

    logic             alu_wb_valid;
    logic [AW-1:0]    alu_wb_addr;
    logic [WIDTH-1:0] alu_wb_data;

    logic             mem_wb_valid;
    logic             mem_wb_ready;
    logic [AW-1:0]    mem_wb_addr;
    logic [WIDTH-1:0] mem_wb_data;

    // The issue stage is the master: it initiates all register-file traffic.
    modport master (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
        output iss_ready,
        output op_valid, op_a, op_b, op_rd, op_rd_we,
        input  op_ready,
        output rf_rd_addr0, rf_rd_addr1, rf_wr_addr0, rf_wr_din0, rf_we0,
        input  rf_dout0, rf_dout1,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  mem_wb_valid, mem_wb_addr, mem_wb_data,
        output mem_wb_ready
    );

    modport slave (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
        input  iss_ready,
        input  op_valid, op_a, op_b, op_rd, op_rd_we,
        output op_ready,
        input  rf_rd_addr0, rf_rd_addr1, rf_wr_addr0, rf_wr_din0, rf_we0,
        output rf_dout0, rf_dout1,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output mem_wb_valid, mem_wb_addr, mem_wb_data,
        input  mem_wb_ready
    );

endinterface

`default_nettype wire

// File: rtl/operand_issue_reg_scoreboard.sv
// ============================================================================
// Module   : operand_issue_reg_scoreboard
// Brief    : Per-register busy bits with set/clear ports and three lookups.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_issue_reg_scoreboard import operand_issue_pkg::*; #(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic          rd_busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clear is applied first so a same-cycle set on the same bit wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];
    assign rd_busy_o  = busy_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/operand_issue.sv
// ============================================================================
// Module   : operand_issue
// Brief    : Hazard-checked operand issue and writeback arbitration for a 2R/1W
//            register file. Define OPERAND_BYPASS_EN for same-cycle forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_issue import operand_issue_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    operand_issue_if.master bus
);

    localparam int AW = addr_width(DEPTH);

    logic             req_valid_q, req_valid_d;
    logic [AW-1:0]    req_rs1_q,   req_rs1_d;
    logic [AW-1:0]    req_rs2_q,   req_rs2_d;
    logic [AW-1:0]    req_rd_q,    req_rd_d;
    logic             req_rd_we_q, req_rd_we_d;

    logic             op_valid_q,  op_valid_d;
    logic [WIDTH-1:0] op_a_q,      op_a_d;
    logic [WIDTH-1:0] op_b_q,      op_b_d;
    logic [AW-1:0]    op_rd_q,     op_rd_d;
    logic             op_rd_we_q,  op_rd_we_d;

    wb_sel_e          w_wb_sel;
    logic             w_wr_valid;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;

    logic             w_rs1_busy, w_rs2_busy, w_rd_busy;
    logic             w_byp_rs1, w_byp_rs2, w_byp_rd;
    logic             w_haz;
    logic             w_fire;
    logic             w_iss_ready;
    logic             w_set_en;
    logic [WIDTH-1:0] w_opa, w_opb;

    // ALU has strict priority; the load path simply waits via mem_wb_ready.
    always_comb begin
        w_wb_sel   = bus.alu_wb_valid ? WB_ALU : WB_MEM;
        w_wr_valid = bus.alu_wb_valid || bus.mem_wb_valid;
        w_wr_addr  = (w_wb_sel == WB_ALU) ? bus.alu_wb_addr : bus.mem_wb_addr;
        w_wr_data  = (w_wb_sel == WB_ALU) ? bus.alu_wb_data : bus.mem_wb_data;
        w_wr_en    = w_wr_valid && (w_wr_addr != '0);
    end

    assign bus.rf_wr_addr0  = w_wr_addr;
    assign bus.rf_wr_din0   = w_wr_data;
    assign bus.rf_we0       = w_wr_en;
    assign bus.mem_wb_ready = !bus.alu_wb_valid;

`ifdef OPERAND_BYPASS_EN
    assign w_byp_rs1 = w_wr_en && (w_wr_addr == req_rs1_q);
    assign w_byp_rs2 = w_wr_en && (w_wr_addr == req_rs2_q);
    assign w_byp_rd  = w_wr_en && (w_wr_addr == req_rd_q);
`else
    assign w_byp_rs1 = 1'b0;
    assign w_byp_rs2 = 1'b0;
    assign w_byp_rd  = 1'b0;
`endif

    assign w_haz = (w_rs1_busy && !w_byp_rs1)
                || (w_rs2_busy && !w_byp_rs2)
                || (req_rd_we_q && w_rd_busy && !w_byp_rd);

    assign w_fire      = req_valid_q && !w_haz && (!op_valid_q || bus.op_ready);
    assign w_iss_ready = !req_valid_q || w_fire;
    assign w_set_en    = w_fire && req_rd_we_q && (req_rd_q != '0);
    assign w_opa       = w_byp_rs1 ? w_wr_data : bus.rf_dout0;
    assign w_opb       = w_byp_rs2 ? w_wr_data : bus.rf_dout1;

    operand_issue_reg_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (w_set_en),
        .set_addr_i (req_rd_q),
        .clr_en_i   (w_wr_en),
        .clr_addr_i (w_wr_addr),
        .rs1_addr_i (req_rs1_q),
        .rs2_addr_i (req_rs2_q),
        .rd_addr_i  (req_rd_q),
        .rs1_busy_o (w_rs1_busy),
        .rs2_busy_o (w_rs2_busy),
        .rd_busy_o  (w_rd_busy)
    );

    always_comb begin
        req_valid_d = req_valid_q;
        req_rs1_d   = req_rs1_q;
        req_rs2_d   = req_rs2_q;
        req_rd_d    = req_rd_q;
        req_rd_we_d = req_rd_we_q;
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_rd_d     = op_rd_q;
        op_rd_we_d  = op_rd_we_q;

        if (bus.iss_valid && w_iss_ready) begin
            req_valid_d = 1'b1;
            req_rs1_d   = bus.iss_rs1;
            req_rs2_d   = bus.iss_rs2;
            req_rd_d    = bus.iss_rd;
            req_rd_we_d = bus.iss_rd_we;
        end else if (w_fire) begin
            req_valid_d = 1'b0;
        end

        if (w_fire) begin
            op_valid_d = 1'b1;
            op_a_d     = w_opa;
            op_b_d     = w_opb;
            op_rd_d    = req_rd_q;
            op_rd_we_d = req_rd_we_q;
        end else if (bus.op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_rs1_q   <= '0;
            req_rs2_q   <= '0;
            req_rd_q    <= '0;
            req_rd_we_q <= 1'b0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_rd_q     <= '0;
            op_rd_we_q  <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_rs1_q   <= req_rs1_d;
            req_rs2_q   <= req_rs2_d;
            req_rd_q    <= req_rd_d;
            req_rd_we_q <= req_rd_we_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_rd_q     <= op_rd_d;
            op_rd_we_q  <= op_rd_we_d;
        end
    end

    assign bus.iss_ready   = w_iss_ready;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_rd       = op_rd_q;
    assign bus.op_rd_we    = op_rd_we_q;
    assign bus.rf_rd_addr0 = req_rs1_q;
    assign bus.rf_rd_addr1 = req_rs2_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_issue.sv
// ============================================================================
// Module   : tb_operand_issue
// Brief    : Scoreboard bench for operand_issue with a behavioural register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_operand_issue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef OPERAND_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [AW-1:0]    rd;
        logic             we;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_issue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] rf_mem [DEPTH];
    assign bus.rf_dout0 = (bus.rf_rd_addr0 == '0) ? '0 : rf_mem[bus.rf_rd_addr0];
    assign bus.rf_dout1 = (bus.rf_rd_addr1 == '0) ? '0 : rf_mem[bus.rf_rd_addr1];
    always @(posedge clk) begin
        if (bus.rf_we0) rf_mem[bus.rf_wr_addr0] <= bus.rf_wr_din0;
    end

    op_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_push   = 0;
    int  n_pop    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every handshake pops the oldest expected operand set.
    always @(negedge clk) begin
        op_t e;
        if (!rst && bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("op_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                n_pop++;
                check_eq("op_a",     bus.op_a,     e.a);
                check_eq("op_b",     bus.op_b,     e.b);
                check_eq("op_rd",    bus.op_rd,    e.rd);
                check_eq("op_rd_we", bus.op_rd_we, e.we);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we, input logic push,
                         input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        int n;
        op_t e;
        bus.iss_valid = 1'b1;
        bus.iss_rs1   = rs1;
        bus.iss_rs2   = rs2;
        bus.iss_rd    = rd;
        bus.iss_rd_we = we;
        n = 0;
        @(negedge clk);
        while (!bus.iss_ready && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check_eq("iss_accept", {63'd0, bus.iss_ready}, 64'd1);
        if (push) begin
            e.a = ea; e.b = eb; e.rd = rd; e.we = we;
            exp_q.push_back(e);
            n_push++;
        end
        tick();
        bus.iss_valid = 1'b0;
    endtask

    task automatic alu_wb(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = addr;
        bus.alu_wb_data  = data;
        tick();
        bus.alu_wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
        bus.iss_rd = '0; bus.iss_rd_we = 1'b0;
        bus.op_ready = 1'b1;
        bus.alu_wb_valid = 1'b0; bus.alu_wb_addr = '0; bus.alu_wb_data = '0;
        bus.mem_wb_valid = 1'b0; bus.mem_wb_addr = '0; bus.mem_wb_data = '0;
        tick();
        tick();
        rst = 1'b0;

        @(negedge clk);
        check_eq("rst_op_valid",  bus.op_valid,  0);
        check_eq("rst_iss_ready", bus.iss_ready, 1);
        check_eq("rst_op_a",      bus.op_a,      0);
        check_eq("rst_op_b",      bus.op_b,      0);
        check_eq("rst_op_rd",     bus.op_rd,     0);
        check_eq("rst_op_rd_we",  bus.op_rd_we,  0);
        check_eq("rst_busy",      dut.u_sb.busy_q, 0);
        tick();

        // Preload x1=5, x2=7 through the writeback port.
        alu_wb(5'd1, 32'd5);
        alu_wb(5'd2, 32'd7);

        // Basic issue and latency.
        do_reset();
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7);
        @(negedge clk);
        check_eq("lat_n_opv", bus.op_valid, 0);
        tick();
        @(negedge clk);
        check_eq("lat_n1_opv", bus.op_valid, 1);
        check_eq("basic_busy", dut.u_sb.busy_q, 32'h0000_0008);
        tick();
        tick();

        // RAW stall resolved by an ALU writeback.
        do_reset();
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7);
        issue(5'd3, 5'd0, 5'd6, 1'b1, 1'b1, 32'hAA, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_eq("raw_hold_opv", bus.op_valid, 0);
                check_eq("raw_hold_rdy", bus.iss_ready, 0);
            end
            tick();
        end
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd3; bus.alu_wb_data = 32'hAA;
        @(negedge clk);
        check_eq("raw_wb_we",  bus.rf_we0, 1);
        check_eq("raw_wb_rdy", bus.iss_ready, {63'd0, BYP});
        tick();
        bus.alu_wb_valid = 1'b0;
        @(negedge clk);
        check_eq("raw_opv_w1", bus.op_valid, {63'd0, BYP});
        tick();
        @(negedge clk);
        check_eq("raw_opv_w2", bus.op_valid, {63'd0, !BYP});
        tick();
        tick();

        // Arbitration: ALU first, load next cycle.
        do_reset();
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 32'd0, 32'd0);
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'd0, 32'd0);
        tick();
        @(negedge clk);
        check_eq("arb_busy_set", dut.u_sb.busy_q, 32'h0000_0030);
        tick();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd4; bus.alu_wb_data = 32'h11;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd5; bus.mem_wb_data = 32'h22;
        @(negedge clk);
        check_eq("arb1_we",   bus.rf_we0,       1);
        check_eq("arb1_addr", bus.rf_wr_addr0,  4);
        check_eq("arb1_din",  bus.rf_wr_din0,   32'h11);
        check_eq("arb1_mrdy", bus.mem_wb_ready, 0);
        tick();
        bus.alu_wb_valid = 1'b0;
        @(negedge clk);
        check_eq("arb2_we",   bus.rf_we0,       1);
        check_eq("arb2_addr", bus.rf_wr_addr0,  5);
        check_eq("arb2_din",  bus.rf_wr_din0,   32'h22);
        check_eq("arb2_mrdy", bus.mem_wb_ready, 1);
        tick();
        bus.mem_wb_valid = 1'b0;
        @(negedge clk);
        check_eq("arb_busy_clr", dut.u_sb.busy_q, 0);
        tick();

        // x0 destination and x0 load writeback.
        do_reset();
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 32'd5, 32'd7);
        tick();
        @(negedge clk);
        check_eq("x0_busy_issue", dut.u_sb.busy_q, 0);
        tick();
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd0; bus.mem_wb_data = 32'h99;
        @(negedge clk);
        check_eq("x0_we",   bus.rf_we0,       0);
        check_eq("x0_mrdy", bus.mem_wb_ready, 1);
        tick();
        bus.mem_wb_valid = 1'b0;
        @(negedge clk);
        check_eq("x0_busy_wb", dut.u_sb.busy_q, 0);
        tick();

        // Same-cycle set and clear on one register: set wins.
        issue(5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'd0, 32'd0);
        alu_wb(5'd11, 32'h5);
        @(negedge clk);
        check_eq("set_wins", dut.u_sb.busy_q, 32'h0000_0800);
        tick();

        // Backpressure with two back-to-back issues.
        do_reset();
        bus.op_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'd5, 32'd7);
        issue(5'd2, 5'd1, 5'd8, 1'b0, 1'b1, 32'd7, 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_opv", bus.op_valid,  1);
            check_eq("bp_a",   bus.op_a,      5);
            check_eq("bp_b",   bus.op_b,      7);
            check_eq("bp_rd",  bus.op_rd,     7);
            check_eq("bp_rdy", bus.iss_ready, 0);
            tick();
        end
        bus.op_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check_eq("bp_drained", exp_q.size(), 0);
        tick();

        // Reset while a request is stalled on a hazard.
        do_reset();
        issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'd0, 32'd0);
        issue(5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        @(negedge clk);
        check_eq("rs_held_rdy",  bus.iss_ready, 0);
        check_eq("rs_held_busy", dut.u_sb.busy_q, 32'h0000_0200);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rs_req_valid", dut.req_valid_q, 0);
        check_eq("rs_op_valid",  bus.op_valid,    0);
        check_eq("rs_busy",      dut.u_sb.busy_q, 0);
        check_eq("rs_iss_ready", bus.iss_ready,   1);
        repeat (3) tick();

        check_eq("sb_empty",   exp_q.size(), 0);
        check_eq("deliveries", n_pop, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Initiator side of the 2-read/1-write register file. Drives both read ports and the single write port.
- Accepts decoded issue requests (rs1, rs2, rd) with a valid/ready handshake.
- Stalls on RAW/WAW hazards using a per-register busy scoreboard, then presents registered operands to execute.
- Arbitrates ALU and memory writeback onto the single write port and clears busy bits on write.

Parameters:
- WIDTH, 32, data width of a register.
- DEPTH, 32, number of architectural registers; address width AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  issue request valid.
- iss_ready  out  1  request register can accept.
- iss_rs1, iss_rs2  in  AW each  source register addresses.
- iss_rd  in  AW  destination register address.
- iss_rd_we  in  1  instruction writes rd.
- op_valid  out  1  registered operands valid.
- op_ready  in  1  execute accepts operands.
- op_a, op_b  out  WIDTH each  operand values for rs1 and rs2.
- op_rd  out  AW  destination, passed through.
- op_rd_we  out  1  passed through.
- rf_rd_addr0, rf_rd_addr1  out  AW each  register-file read addresses (rs1, rs2 of the held request).
- rf_dout0, rf_dout1  in  WIDTH each  asynchronous read data.
- rf_wr_addr0  out  AW  write address.
- rf_wr_din0  out  WIDTH  write data.
- rf_we0  out  1  write enable.
- alu_wb_valid  in  1  ALU writeback; no backpressure.
- alu_wb_addr  in  AW  ALU writeback address.
- alu_wb_data  in  WIDTH  ALU writeback data.
- mem_wb_valid  in  1  load writeback valid.
- mem_wb_ready  out  1  load writeback accepted.
- mem_wb_addr  in  AW  load writeback address.
- mem_wb_data  in  WIDTH  load writeback data.

Behaviour:
- Reset (rst=1 at an edge):
  - req_valid, op_valid = 0.
  - op_a, op_b, op_rd = 0; op_rd_we = 0.
  - busy[] all 0.
  - Takes effect next cycle, including mid-stall or mid-hold; pending requests and operands are dropped.
- Request register:
  - Loaded on iss_valid && iss_ready.
  - iss_ready = !req_valid || req_fire. Combinational; allows one issue per cycle.
- Hazard:
  - haz = busy[rs1] || busy[rs2] || (iss_rd_we && busy[rd]), evaluated on the held request.
  - busy[0] is permanently 0.
  - A writeback in the current cycle that matches the address counts as clear only with the bypass option (see Optional Feature).
- req_fire = req_valid && !haz && (!op_valid || op_ready).
  - On req_fire: op_a/op_b load from rf_dout0/1 (or bypass); op_rd and op_rd_we load; op_valid = 1.
  - If req_rd_we && rd != 0, set busy[rd].
- Latency:
  - Issue accepted at edge N.
  - With no hazard, op_valid is high after edge N+1.
- Output hold:
  - While op_valid && !op_ready, all op_* stay stable and no new fire occurs.
  - op_valid drops after an op_ready handshake with no concurrent fire.
- Write arbitration:
  - ALU has strict priority.
  - mem_wb_ready = !alu_wb_valid.
  - Selected source drives rf_wr_addr0 and rf_wr_din0.
  - rf_we0 = selected valid && addr != 0.
  - A writeback to x0 is still accepted (mem_wb_ready unaffected) but is never written.
- Busy clear: on any rf_we0, clear busy[rf_wr_addr0].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- A busy bit may clear from a writeback with no matching issue (spurious). This is legal; no error is flagged.

Optional Feature:
- Macro OPERAND_BYPASS_EN.
- Defined:
  - If rf_we0 and rf_wr_addr0 equals rs1 (or rs2), that operand is taken from rf_wr_din0 in the same cycle.
  - The matching busy bit counts as clear; for rd it counts as clear for WAW.
  - RAW stall ends in the writeback cycle.
- Undefined:
  - No forwarding; the request waits for the busy bit to clear.
  - Operands are read from the register file the following cycle, costing one extra cycle per resolved hazard.

Decomposition:
- Shared package holds:
  - WIDTH and DEPTH defaults.
  - AW derivation.
  - Writeback source select encoding (WB_ALU, WB_MEM).
- One natural sub-module: reg_scoreboard.
  - Contents: busy vector, set/clear ports, three lookup ports, set-wins rule, busy[0] tie-off.

Test Plan:
- Basic issue:
  - Stimulus: reset, regfile x1=5, x2=7; issue rs1=1, rs2=2, rd=3, rd_we=1.
  - Required: op_valid one cycle after acceptance; op_a=5, op_b=7, op_rd=3; busy[3]=1.
- RAW stall:
  - Stimulus: issue rd=3, then rs1=3, rs2=0; ALU writeback addr=3, data=0xAA four cycles later.
  - Required: second op held until then; op_a=0xAA. Fires on the writeback cycle with OPERAND_BYPASS_EN, one cycle later without.
- Arbitration:
  - Stimulus: alu_wb (addr=4, 0x11) and mem_wb (addr=5, 0x22) in the same cycle.
  - Required: rf_we0 writes 4/0x11; mem_wb_ready=0; next cycle writes 5/0x22; busy[4] and busy[5] cleared.
- x0 handling:
  - Stimulus: issue rd=0, rd_we=1, then mem_wb addr=0.
  - Required: busy unchanged; rf_we0=0; mem_wb_ready=1.
- Backpressure:
  - Stimulus: op_ready=0 for 3 cycles with two back-to-back issues.
  - Required: op_* stable; iss_ready=0 while the request register is full; both ops delivered in order once op_ready=1.
- Reset mid-stall:
  - Stimulus: rst=1 for 1 cycle while a request is held on a hazard.
  - Required: next cycle req_valid=0, op_valid=0, all busy=0, iss_ready=1.
